// File: rtl/commit_regfile_mp_pkg.sv
// Shared widths and lane helpers for the multi-port commit register file.
// Helpers operate on a fixed LANE_MAX-wide vector; callers zero-extend narrower lane masks.
package commit_regfile_mp_pkg;

  localparam int unsigned XLEN_DEF = 64;
  localparam int unsigned LANE_MAX = 32;

  function automatic int unsigned addr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned popcount(input logic [LANE_MAX-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < LANE_MAX; i++) c += 32'(v[i]);
    return c;
  endfunction

  // Highest set bit wins: the highest-index lane is the youngest producer.
  function automatic int unsigned youngest_lane(input logic [LANE_MAX-1:0] hit);
    int unsigned sel;
    sel = 0;
    for (int i = 0; i < LANE_MAX; i++) begin
      if (hit[i]) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/commit_regfile_mp_scoreboard.sv
// Per-register busy scoreboard: flush > issue-set > write-back-clear, x0 never busy.
// rd_busy is combinational and masked by same-cycle write-backs; no backpressure.
module commit_scoreboard
  import commit_regfile_mp_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 4,
  parameter int unsigned NWB  = 2,
  parameter int unsigned AW   = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWB-1:0]    wb_valid,
  input  logic [NWB*AW-1:0] wb_addr,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rd,
  input  logic              flush
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] wb_hit;

  always_comb begin
    wb_hit = '0;
    for (int j = 0; j < NWB; j++) begin
      if (wb_valid[j]) wb_hit[wb_addr[j*AW +: AW]] = 1'b1;
    end
    busy_d = busy_q & ~wb_hit;
    // A same-cycle issue names a new producer, so it beats the clear.
    if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
    if (flush) busy_d = '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_busy
    assign rd_busy[i] = busy_q[rd_addr[i*AW +: AW]] & ~wb_hit[rd_addr[i*AW +: AW]];
  end

endmodule

// File: rtl/commit_regfile_mp.sv
// Multi-port integer register file with write-back bypass, busy scoreboard and retire counter.
// Reads are 0-cycle combinational, writes land at the edge; no backpressure on any lane.
module commit_regfile_mp
  import commit_regfile_mp_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = 32,
  parameter int unsigned NRD   = 4,
  parameter int unsigned NWB   = 2,
  parameter int unsigned CNT_W = 64,
  localparam int unsigned AW   = addr_w(NREG),
  localparam int unsigned CW   = addr_w(NWB + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*AW-1:0]   wb_addr,
  input  logic [NWB*XLEN-1:0] wb_data,
  input  logic [NWB-1:0]      commit,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic [CNT_W-1:0]    inst_counter,
  output logic [CW-1:0]       last_commit_cnt
);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;
  logic [CW-1:0]    last_cnt_q, last_cnt_d;
  int unsigned      commit_pc;

  // Ascending lane order lets the youngest lane overwrite older same-address writes.
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWB; j++) begin
      if (wb_valid[j] && wb_addr[j*AW +: AW] != '0)
        regs_d[wb_addr[j*AW +: AW]] = wb_data[j*XLEN +: XLEN];
    end
  end

  always_comb begin
    commit_pc  = popcount(LANE_MAX'(commit));
    inst_cnt_d = inst_cnt_q + CNT_W'(commit_pc);
    last_cnt_d = CW'(commit_pc);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      inst_cnt_q <= '0;
      last_cnt_q <= '0;
    end else begin
      regs_q     <= regs_d;
      inst_cnt_q <= inst_cnt_d;
      last_cnt_q <= last_cnt_d;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]       addr;
    logic [LANE_MAX-1:0] hit;
    int unsigned         sel;

    assign addr = rd_addr[i*AW +: AW];

    always_comb begin
      hit = '0;
      for (int j = 0; j < NWB; j++) hit[j] = wb_valid[j] && (wb_addr[j*AW +: AW] == addr);
      sel = youngest_lane(hit);
    end

    assign rd_data[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                     (|hit)       ? wb_data[sel*XLEN +: XLEN] :
                                                    regs_q[addr];
  end

  commit_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .NWB  (NWB),
    .AW   (AW)
  ) u_scoreboard (
    .clock       (clock),
    .reset       (reset),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .flush       (flush)
  );

  assign inst_counter    = inst_cnt_q;
  assign last_commit_cnt = last_cnt_q;

endmodule

// File: tb/tb_commit_regfile_mp.sv
// Directed bench for commit_regfile_mp; a second CNT_W=8 instance shares stimulus to exercise counter wrap.
module tb_commit_regfile_mp;

  localparam int XLEN = 64;
  localparam int NRD  = 4;
  localparam int NWB  = 2;
  localparam int AW   = 5;
  localparam int CW   = 2;

  logic                clock = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data, rd_data8;
  logic [NRD-1:0]      rd_busy, rd_busy8;
  logic [NWB-1:0]      wb_valid;
  logic [NWB*AW-1:0]   wb_addr;
  logic [NWB*XLEN-1:0] wb_data;
  logic [NWB-1:0]      commit;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic [63:0]         inst_counter;
  logic [7:0]          inst_counter8;
  logic [CW-1:0]       last_commit_cnt, last_commit_cnt8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  commit_regfile_mp #(.XLEN(64), .NREG(32), .NRD(4), .NWB(2), .CNT_W(64)) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .commit(commit),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .inst_counter(inst_counter), .last_commit_cnt(last_commit_cnt)
  );

  commit_regfile_mp #(.XLEN(64), .NREG(32), .NRD(4), .NWB(2), .CNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data8), .rd_busy(rd_busy8),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .commit(commit),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .inst_counter(inst_counter8), .last_commit_cnt(last_commit_cnt8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wb(input int j, input logic v, input logic [AW-1:0] a, input logic [63:0] d);
    wb_valid[j]            = v;
    wb_addr[j*AW +: AW]    = a;
    wb_data[j*XLEN +: XLEN] = d;
  endtask

  function automatic logic [63:0] rd(input int i);
    return rd_data[i*XLEN +: XLEN];
  endfunction

  initial begin
    reset = 1'b1; rd_addr = '0; wb_valid = '0; wb_addr = '0; wb_data = '0;
    commit = '0; issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    set_rd(0, 5'd1); set_rd(1, 5'd2); set_rd(2, 5'd3); set_rd(3, 5'd31);
    #1;
    for (int i = 0; i < NRD; i++) check($sformatf("reset_rd%0d", i), rd(i), 64'h0);
    check("reset_busy", 64'(rd_busy), 64'h0);
    check("reset_cnt", inst_counter, 64'h0);
    check("reset_last", 64'(last_commit_cnt), 64'h0);
    step();
    reset = 1'b0;

    // x0 ignores writes and never bypasses
    set_wb(0, 1'b1, 5'd0, 64'h5); set_rd(0, 5'd0);
    #1 check("x0_bypass", rd(0), 64'h0);
    step();
    set_wb(0, 1'b0, 5'd0, 64'h0);
    #1 check("x0_file", rd(0), 64'h0);

    // Same-address lanes: youngest lane wins both bypass and file
    set_wb(0, 1'b1, 5'd5, 64'h11); set_wb(1, 1'b1, 5'd5, 64'h22);
    set_rd(0, 5'd5); set_rd(1, 5'd5);
    #1 check("byp_young0", rd(0), 64'h22);
    check("byp_young1", rd(1), 64'h22);
    step();
    set_wb(0, 1'b0, 5'd0, 64'h0); set_wb(1, 1'b0, 5'd0, 64'h0);
    #1 check("file_x5", rd(0), 64'h22);

    // Distinct lanes bypass independently
    set_wb(0, 1'b1, 5'd6, 64'h33); set_wb(1, 1'b1, 5'd8, 64'h44);
    set_rd(2, 5'd6); set_rd(3, 5'd8);
    #1 check("byp_lane0", rd(2), 64'h33);
    check("byp_lane1", rd(3), 64'h44);
    step();
    set_wb(0, 1'b0, 5'd0, 64'h0); set_wb(1, 1'b0, 5'd0, 64'h0);
    #1 check("file_x6", rd(2), 64'h33);
    check("file_x8", rd(3), 64'h44);

    // Scoreboard: issue x7, then write-back masks busy and bypasses data
    issue_valid = 1'b1; issue_rd = 5'd7; set_rd(1, 5'd7);
    #1 check("busy_pre_issue", 64'(rd_busy[1]), 64'h0);
    step();
    issue_valid = 1'b0;
    #1 check("busy_x7", 64'(rd_busy[1]), 64'h1);
    set_wb(1, 1'b1, 5'd7, 64'h77);
    #1 check("busy_x7_masked", 64'(rd_busy[1]), 64'h0);
    check("byp_x7", rd(1), 64'h77);
    step();
    set_wb(1, 1'b0, 5'd0, 64'h0);
    #1 check("busy_x7_clr", 64'(rd_busy[1]), 64'h0);
    check("file_x7", rd(1), 64'h77);

    // Issue and write-back to x9 together: set wins
    issue_valid = 1'b1; issue_rd = 5'd9; set_wb(0, 1'b1, 5'd9, 64'h99);
    step();
    issue_valid = 1'b0; set_wb(0, 1'b0, 5'd0, 64'h0); set_rd(2, 5'd9); set_rd(3, 5'd3);
    #1 check("busy_x9_setwins", 64'(rd_busy[2]), 64'h1);
    check("file_x9", rd(2), 64'h99);

    // Flush overrides a concurrent issue
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    flush = 1'b0; issue_valid = 1'b0;
    #1 check("flush_x9", 64'(rd_busy[2]), 64'h0);
    check("flush_x3", 64'(rd_busy[3]), 64'h0);
    check("flush_keeps_file", rd(2), 64'h99);

    // Issue to x0 ignored
    issue_valid = 1'b1; issue_rd = 5'd0; set_rd(0, 5'd0);
    step();
    issue_valid = 1'b0;
    #1 check("busy_x0", 64'(rd_busy[0]), 64'h0);

    // Retire counting: 3x2 + 1 = 7
    check("cnt_before", inst_counter, 64'h0);
    commit = 2'b11;
    repeat (3) step();
    check("last_two", 64'(last_commit_cnt), 64'h2);
    commit = 2'b01;
    step();
    check("cnt_7", inst_counter, 64'd7);
    check("last_one", 64'(last_commit_cnt), 64'h1);
    check("cnt8_7", 64'(inst_counter8), 64'd7);
    commit = 2'b00;
    step();
    check("last_zero", 64'(last_commit_cnt), 64'h0);
    check("cnt_hold", inst_counter, 64'd7);

    // Drive the 8-bit counter to 255 then across the wrap
    commit = 2'b11;
    repeat (124) step();
    check("cnt8_255", 64'(inst_counter8), 64'd255);
    check("cnt_255", inst_counter, 64'd255);
    commit = 2'b01;
    step();
    check("cnt8_wrap0", 64'(inst_counter8), 64'd0);
    check("cnt_256", inst_counter, 64'd256);
    step();
    check("cnt8_wrap1", 64'(inst_counter8), 64'd1);
    check("last8_one", 64'(last_commit_cnt8), 64'h1);
    commit = 2'b00;

    // Asynchronous reset between edges discards an in-flight write
    issue_valid = 1'b1; issue_rd = 5'd11;
    step();
    issue_valid = 1'b0; set_rd(0, 5'd5); set_rd(1, 5'd11);
    #1 check("busy_x11", 64'(rd_busy[1]), 64'h1);
    set_wb(0, 1'b1, 5'd10, 64'hAB);
    #2 reset = 1'b1;
    #1 check("arst_x5", rd(0), 64'h0);
    check("arst_busy", 64'(rd_busy[1]), 64'h0);
    check("arst_cnt", inst_counter, 64'h0);
    check("arst_cnt8", 64'(inst_counter8), 64'h0);
    check("arst_last", 64'(last_commit_cnt), 64'h0);
    step();
    set_wb(0, 1'b0, 5'd0, 64'h0);
    reset = 1'b0; set_rd(2, 5'd10);
    #1 check("arst_no_write", rd(2), 64'h0);
    step();
    check("post_rst_x10", rd(2), 64'h0);
    check("post_rst_cnt", inst_counter, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
